instruction_fetch: RTL and testbench

Program-side counterpart to the instruction decoder. It owns the program counter, the instruction register that drives instr_current, and the 8-level hardware return stack. It acts on the decoder's fetch controls: instr_rd_en, instr_flush, pc_incr_en, pc_j_en, stack_push and stack_pop. It also presents the program memory address and latches the returned instruction word, giving the core its one-instruction prefetch.

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch_return_stack.sv | 57 +++++
 rtl/instruction_fetch.sv | 80 ++++++++
 tb/tb_instruction_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_pkg : shared fetch-side constants and field slices |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package instruction_fetch_pkg;

  localparam int          PC_W        = 13;
  localparam int          STK_DEPTH   = 8;
  localparam int          INSTR_W     = 14;
  localparam logic [13:0] NOP         = 14'h0000;

  // GOTO/CALL literal field and the PCLATH bits that extend it
  localparam int          LIT_MSB     = 10;
  localparam int          LIT_LSB     = 0;
  localparam int          PCLATH_JMSB = 4;
  localparam int          PCLATH_JLSB = 3;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_return_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_return_stack : circular LIFO of return addresses   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module instruction_fetch_return_stack #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             ovf,
  output logic             unf
);

  localparam int SPW = $clog2(DEPTH);
  localparam int CW  = SPW + 1;
  localparam logic [CW-1:0]  c_full = CW'(DEPTH);
  localparam logic [SPW-1:0] c_one  = SPW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0]   sp;
  logic [CW-1:0]    count;
  logic             do_push;

  // Pop has priority; a simultaneous push is dropped.
  assign do_push = push && !pop;
  assign dout    = mem[sp - c_one];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (pop) begin
      sp <= sp - c_one;
      if (count == '0) unf <= 1'b1;
      else             count <= count - CW'(1);
    end else if (do_push) begin
      sp <= sp + c_one;
      if (count == c_full) ovf <= 1'b1;
      else                 count <= count + CW'(1);
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[sp] <= din;
  end

endmodule : instruction_fetch_return_stack
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch : program counter, instruction register, stack     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          PC_WIDTH    = PC_W,
  parameter int          STACK_DEPTH = STK_DEPTH,
  parameter logic [13:0] NOP_WORD    = NOP
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [13:0]         prog_data,
  output logic [13:0]         instr_current,
  input  logic                instr_rd_en,
  input  logic                instr_flush,
  input  logic                pc_incr_en,
  input  logic                pc_j_en,
  input  logic                stack_push,
  input  logic                stack_pop,
  input  logic [4:0]          pclath,
  input  logic                pcl_wr_en,
  input  logic [7:0]          pcl_wr_data,
  output logic [7:0]          pcl,
  output logic                stk_ovf,
  output logic                stk_unf
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] stk_top;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pcl_target;

  assign jump_target = PC_WIDTH'({pclath[PCLATH_JMSB:PCLATH_JLSB],
                                  instr_current[LIT_MSB:LIT_LSB]});
  assign pcl_target  = PC_WIDTH'({pclath, pcl_wr_data});

  assign prog_addr = pc;
  assign pcl       = pc[7:0];

  always_comb begin
    pc_next = pc;
    if (stack_pop)       pc_next = stk_top;
    else if (pc_j_en)    pc_next = jump_target;
    else if (pcl_wr_en)  pc_next = pcl_target;
    else if (pc_incr_en) pc_next = pc + PC_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= '0;
      instr_current <= NOP_WORD;
    end else begin
      pc <= pc_next;
      if (instr_flush)      instr_current <= NOP_WORD;
      else if (instr_rd_en) instr_current <= prog_data;
    end
  end

  // Pre-edge pc is already the return address thanks to the prefetch.
  instruction_fetch_return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (stack_push),
    .pop  (stack_pop),
    .din  (pc),
    .dout (stk_top),
    .ovf  (stk_ovf),
    .unf  (stk_unf)
  );

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instruction_fetch : directed self-checking bench                  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] prog_addr;
  logic [13:0] prog_data;
  logic [13:0] instr_current;
  logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en;
  logic        stack_push, stack_pop, pcl_wr_en;
  logic [4:0]  pclath;
  logic [7:0]  pcl_wr_data;
  logic [7:0]  pcl;
  logic        stk_ovf, stk_unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .instr_current (instr_current),
    .instr_rd_en   (instr_rd_en),
    .instr_flush   (instr_flush),
    .pc_incr_en    (pc_incr_en),
    .pc_j_en       (pc_j_en),
    .stack_push    (stack_push),
    .stack_pop     (stack_pop),
    .pclath        (pclath),
    .pcl_wr_en     (pcl_wr_en),
    .pcl_wr_data   (pcl_wr_data),
    .pcl           (pcl),
    .stk_ovf       (stk_ovf),
    .stk_unf       (stk_unf)
  );

  task automatic idle();
    instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0; pc_j_en = 0;
    stack_push = 0; stack_pop = 0; pcl_wr_en = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    pclath = 0; pcl_wr_data = 0; prog_data = 0;
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if (prog_addr !== 13'h0000 || instr_current !== 14'h0000 || pcl !== 8'h00 ||
        stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state addr=%h ir=%h pcl=%h ovf=%b unf=%b want 0000/0000/00/0/0",
               prog_addr, instr_current, pcl, stk_ovf, stk_unf);
    end
    rst = 0;
  endtask

  task automatic test_fetch();
    checks++;
    if (instr_current !== 14'h0000 || prog_addr !== 13'h0000) begin
      errors++;
      $display("FAIL fetch_pre ir=%h addr=%h want 0000/0000", instr_current, prog_addr);
    end
    prog_data = 14'h3055; instr_rd_en = 1; pc_incr_en = 1;
    tick();
    checks++;
    if (instr_current !== 14'h3055 || prog_addr !== 13'h0001) begin
      errors++;
      $display("FAIL fetch_post ir=%h addr=%h want 3055/0001", instr_current, prog_addr);
    end
    // flush wins over read
    prog_data = 14'h1111; instr_rd_en = 1; instr_flush = 1;
    tick();
    checks++;
    if (instr_current !== 14'h0000 || prog_addr !== 13'h0001) begin
      errors++;
      $display("FAIL flush_prio ir=%h addr=%h want 0000/0001", instr_current, prog_addr);
    end
  endtask

  task automatic test_goto();
    prog_data = 14'h2ABC; instr_rd_en = 1;
    tick();
    pclath = 5'b11000; pc_j_en = 1; instr_flush = 1;
    tick();
    checks++;
    if (prog_addr !== 13'h1ABC || instr_current !== 14'h0000) begin
      errors++;
      $display("FAIL goto addr=%h ir=%h want 1abc/0000", prog_addr, instr_current);
    end
  endtask

  task automatic test_call_return();
    do_reset();
    pclath = 5'h01; pcl_wr_data = 8'h23; pcl_wr_en = 1;
    tick();
    checks++;
    if (prog_addr !== 13'h0123 || pcl !== 8'h23) begin
      errors++;
      $display("FAIL pcl_set addr=%h pcl=%h want 0123/23", prog_addr, pcl);
    end
    prog_data = 14'h2200; instr_rd_en = 1;
    tick();
    pclath = 5'h00; pc_j_en = 1; stack_push = 1; instr_flush = 1;
    tick();
    checks++;
    if (prog_addr !== 13'h0200 || instr_current !== 14'h0000) begin
      errors++;
      $display("FAIL call addr=%h ir=%h want 0200/0000", prog_addr, instr_current);
    end
    pc_incr_en = 1;
    tick();
    stack_pop = 1; instr_flush = 1;
    tick();
    checks++;
    if (prog_addr !== 13'h0123 || stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
      errors++;
      $display("FAIL return addr=%h ovf=%b unf=%b want 0123/0/0", prog_addr, stk_ovf, stk_unf);
    end
  endtask

  task automatic test_stack_overflow();
    do_reset();
    pclath = 5'h00;
    for (int k = 1; k <= 9; k++) begin
      pcl_wr_data = 8'(k); pcl_wr_en = 1;
      tick();
      pc_j_en = 1; stack_push = 1;
      tick();
      if (k == 8) begin
        checks++;
        if (stk_ovf !== 1'b0) begin
          errors++;
          $display("FAIL ovf_at_8 ovf=%b want 0", stk_ovf);
        end
      end
    end
    checks++;
    if (stk_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_at_9 ovf=%b want 1", stk_ovf);
    end
    for (int k = 9; k >= 2; k--) begin
      stack_pop = 1;
      tick();
      checks++;
      if (prog_addr !== 13'(k)) begin
        errors++;
        $display("FAIL pop_%0d addr=%h want %h", k, prog_addr, 13'(k));
      end
    end
    checks++;
    if (stk_unf !== 1'b0 || stk_ovf !== 1'b1) begin
      errors++;
      $display("FAIL flags_after_pops ovf=%b unf=%b want 1/0", stk_ovf, stk_unf);
    end
    stack_pop = 1;
    tick();
    checks++;
    if (stk_unf !== 1'b1 || prog_addr !== 13'h0009) begin
      errors++;
      $display("FAIL underflow unf=%b addr=%h want 1/0009", stk_unf, prog_addr);
    end
  endtask

  task automatic test_wrap_pcl();
    do_reset();
    pclath = 5'h1F; pcl_wr_data = 8'hFF; pcl_wr_en = 1;
    tick();
    pc_incr_en = 1;
    tick();
    checks++;
    if (prog_addr !== 13'h0000) begin
      errors++;
      $display("FAIL pc_wrap addr=%h want 0000", prog_addr);
    end
    pclath = 5'h02; pcl_wr_data = 8'h40; pcl_wr_en = 1;
    tick();
    checks++;
    if (prog_addr !== 13'h0240 || pcl !== 8'h40) begin
      errors++;
      $display("FAIL pcl_write addr=%h pcl=%h want 0240/40", prog_addr, pcl);
    end
    // jump beats pcl write and increment
    prog_data = 14'h0011; instr_rd_en = 1;
    tick();
    pclath = 5'h08; pc_j_en = 1; pcl_wr_en = 1; pc_incr_en = 1; pcl_wr_data = 8'h77;
    tick();
    checks++;
    if (prog_addr !== 13'h0811) begin
      errors++;
      $display("FAIL jump_prio addr=%h want 0811", prog_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    stack_pop = 1;
    tick();
    pclath = 5'h00; pc_j_en = 1; stack_push = 1;
    tick();
    pclath = 5'h04; pcl_wr_data = 8'h56; pcl_wr_en = 1;
    tick();
    prog_data = 14'h1234; instr_rd_en = 1;
    tick();
    checks++;
    if (prog_addr !== 13'h0456 || instr_current !== 14'h1234 || stk_unf !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset addr=%h ir=%h unf=%b want 0456/1234/1", prog_addr, instr_current, stk_unf);
    end
    #3;
    rst = 1; pc_incr_en = 1;
    #1;
    checks++;
    if (prog_addr !== 13'h0000 || instr_current !== 14'h0000 || stk_unf !== 1'b0 ||
        stk_ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset addr=%h ir=%h ovf=%b unf=%b want 0000/0000/0/0",
               prog_addr, instr_current, stk_ovf, stk_unf);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (prog_addr !== 13'h0000) begin
      errors++;
      $display("FAIL incr_in_reset addr=%h want 0000", prog_addr);
    end
    rst = 0; idle();
    stack_pop = 1;
    tick();
    checks++;
    if (stk_unf !== 1'b1) begin
      errors++;
      $display("FAIL count_cleared unf=%b want 1", stk_unf);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_goto();
    test_call_return();
    test_stack_overflow();
    test_wrap_pcl();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
